// File: rtl/debounce_multi_pkg.sv
// rtl/debounce_multi_pkg.sv - shared defaults, counter width helper and per-channel output record
package debounce_multi_pkg;

  localparam int DB_SYNC_STAGES  = 2;
  localparam int DB_STABLE_TICKS = 16;

  // Counter must hold 0..STABLE_TICKS-1; sized like $clog2(STABLE_TICKS+1), never below 1 bit.
  function automatic int cnt_width(input int ticks);
    return (ticks < 1) ? 1 : $clog2(ticks + 1);
  endfunction

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } chan_out_t;

endpackage

// File: rtl/debounce_multi_if.sv
// rtl/debounce_multi_if.sv - pin-side inputs and debounced outputs of the multi-channel debouncer
interface debounce_multi_if #(
  parameter int CH = 4
);
  logic          tick_en;
  logic [CH-1:0] din;
  logic [CH-1:0] dout;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;

  modport master (output tick_en, output din, input dout, input rise, input fall);
  modport slave  (input tick_en, input din, output dout, output rise, output fall);
endinterface

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one channel: sync chain, stability counter, debounced level, edge pulses
module debounce_chan
  import debounce_multi_pkg::*;
#(
  parameter int SYNC_STAGES  = DB_SYNC_STAGES,
  parameter int STABLE_TICKS = DB_STABLE_TICKS,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      tick_en,
  input  logic      din,
  output chan_out_t q
);

  localparam int CW = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CW-1:0]          cnt;
  logic                   level;
  logic                   rise_q;
  logic                   fall_q;
  logic                   accept;

  assign s      = sync[SYNC_STAGES-1] ^ ACTIVE_LOW;
  assign accept = (s != level) && tick_en && (cnt == LAST);

  // Synchroniser runs every clock; only the qualification counter is gated by tick_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      level  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= accept & s;
      fall_q <= accept & ~s;
      if (s == level) begin
        cnt <= '0;
      end else if (tick_en) begin
        if (cnt == LAST) begin
          level <= s;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign q.level = level;
  assign q.rise  = rise_q;
  assign q.fall  = fall_q;

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - N independent debounce channels sharing one sample strobe
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int CH           = 4,
  parameter int SYNC_STAGES  = DB_SYNC_STAGES,
  parameter int STABLE_TICKS = DB_STABLE_TICKS,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  debounce_multi_if.slave  bus
);

  if (CH < 1) begin : g_bad_ch
    $error("debounce_multi: CH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_multi: SYNC_STAGES must be >= 2");
  end
  if (STABLE_TICKS < 1) begin : g_bad_ticks
    $error("debounce_multi: STABLE_TICKS must be >= 1");
  end

  logic [CH-1:0] dout_v;
  logic [CH-1:0] rise_v;
  logic [CH-1:0] fall_v;

  for (genvar i = 0; i < CH; i++) begin : g_chan
    chan_out_t co;

    debounce_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_TICKS (STABLE_TICKS),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .tick_en (bus.tick_en),
      .din     (bus.din[i]),
      .q       (co)
    );

    assign dout_v[i] = co.level;
    assign rise_v[i] = co.rise;
    assign fall_v[i] = co.fall;
  end

  assign bus.dout = dout_v;
  assign bus.rise = rise_v;
  assign bus.fall = fall_v;

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - table, corner-case and randomized checks of debounce_multi against a behavioural model
module tb_debounce_multi;

  localparam int CH     = 4;
  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  debounce_multi_if #(.CH(CH)) bus0 ();
  debounce_multi_if #(.CH(CH)) bus1 ();

  debounce_multi #(.CH(CH), .SYNC_STAGES(SYNC), .STABLE_TICKS(STABLE), .ACTIVE_LOW(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  // Second copy sees the inverted pins, so in steady state it must track dut0.
  debounce_multi #(.CH(CH), .SYNC_STAGES(SYNC), .STABLE_TICKS(STABLE), .ACTIVE_LOW(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: a level is accepted once the pin value seen SYNC edges ago has disagreed
  // with the output for STABLE ticked edges in a row.
  logic [CH-1:0] m_pipe [2][SYNC];
  int            m_run  [2][CH];
  logic [CH-1:0] m_dout [2];
  logic [CH-1:0] m_rise [2];
  logic [CH-1:0] m_fall [2];

  task automatic model_clear();
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < SYNC; k++) m_pipe[u][k] = '0;
      for (int c = 0; c < CH; c++) m_run[u][c] = 0;
      m_dout[u] = '0;
      m_rise[u] = '0;
      m_fall[u] = '0;
    end
  endtask

  task automatic model_edge(input logic [CH-1:0] d, input logic t);
    logic [CH-1:0] s;
    logic [CH-1:0] prev;
    for (int u = 0; u < 2; u++) begin
      s    = m_pipe[u][SYNC-1] ^ ((u == 1) ? {CH{1'b1}} : {CH{1'b0}});
      prev = m_dout[u];
      for (int c = 0; c < CH; c++) begin
        if (s[c] == prev[c]) m_run[u][c] = 0;
        else if (t) begin
          m_run[u][c] = m_run[u][c] + 1;
          if (m_run[u][c] >= STABLE) begin
            m_dout[u][c] = s[c];
            m_run[u][c]  = 0;
          end
        end
      end
      m_rise[u] = m_dout[u] & ~prev;
      m_fall[u] = ~m_dout[u] & prev;
      for (int k = SYNC - 1; k > 0; k--) m_pipe[u][k] = m_pipe[u][k-1];
      m_pipe[u][0] = (u == 1) ? ~d : d;
    end
  endtask

  task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic set_in(input logic [CH-1:0] d, input logic t);
    bus0.din     = d;
    bus1.din     = ~d;
    bus0.tick_en = t;
    bus1.tick_en = t;
  endtask

  // Called at a falling edge: drive, clock once, then compare both DUTs with the model.
  task automatic cycle(input logic [CH-1:0] d, input logic t);
    set_in(d, t);
    @(posedge clk);
    if (reset) model_edge(d, t);
    @(negedge clk);
    chk("dout0", bus0.dout, m_dout[0]);
    chk("rise0", bus0.rise, m_rise[0]);
    chk("fall0", bus0.fall, m_fall[0]);
    chk("dout1", bus1.dout, m_dout[1]);
    chk("rise1", bus1.rise, m_rise[1]);
    chk("fall1", bus1.fall, m_fall[1]);
  endtask

  task automatic do_reset(input logic [CH-1:0] d, input int ncyc);
    reset = 1'b0;
    set_in(d, 1'b1);
    model_clear();
    #1;
    chk("rst_dout0", bus0.dout, '0);
    chk("rst_rise0", bus0.rise, '0);
    chk("rst_fall0", bus0.fall, '0);
    chk("rst_dout1", bus1.dout, '0);
    for (int i = 0; i < ncyc; i++) cycle(d, 1'b1);
    reset = 1'b1;
  endtask

  typedef struct {
    bit            rst;
    logic [CH-1:0] din;
    logic          tick;
    logic [CH-1:0] dout;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit r, input logic [CH-1:0] d, input logic t,
                              input logic [CH-1:0] o, input logic [CH-1:0] ri,
                              input logic [CH-1:0] fa);
    vec_t v;
    v.rst = r; v.din = d; v.tick = t; v.dout = o; v.rise = ri; v.fall = fa;
    return v;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int            rise_cnt;
    int            fall_cnt;
    int            rise_edge;
    int            hit;
    logic [CH-1:0] d;
    logic [CH-1:0] bounce [6];

    // Pins high through reset release, then a clean step and a maximal rejected glitch.
    tbl.push_back(mk(1, 4'hF, 1, 4'h0, 4'h0, 4'h0));
    for (int k = 1; k <= 7; k++)
      tbl.push_back(mk(0, 4'hF, 1, (k >= 6) ? 4'hF : 4'h0, (k == 6) ? 4'hF : 4'h0, 4'h0));
    tbl.push_back(mk(1, 4'h0, 1, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 1, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 1, 4'h0, 4'h0, 4'h0));
    for (int k = 1; k <= 7; k++)
      tbl.push_back(mk(0, 4'h1, 1, (k >= 6) ? 4'h1 : 4'h0, (k == 6) ? 4'h1 : 4'h0, 4'h0));
    for (int k = 1; k <= 3; k++) tbl.push_back(mk(0, 4'h3, 1, 4'h1, 4'h0, 4'h0));
    for (int k = 1; k <= 6; k++) tbl.push_back(mk(0, 4'h1, 1, 4'h1, 4'h0, 4'h0));

    set_in('0, 1'b1);
    model_clear();
    #12;
    @(negedge clk);

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        do_reset(tbl[i].din, 2);
      end else begin
        cycle(tbl[i].din, tbl[i].tick);
        chk("tbl_dout", bus0.dout, tbl[i].dout);
        chk("tbl_rise", bus0.rise, tbl[i].rise);
        chk("tbl_fall", bus0.fall, tbl[i].fall);
      end
    end

    // Active-low copy idles with pins high: must stay released with no pulses.
    do_reset(4'h0, 2);
    for (int k = 0; k < 8; k++) begin
      cycle(4'h0, 1'b1);
      chk("al_idle_out", bus1.dout | bus1.rise | bus1.fall, 4'h0);
    end

    // Bounce on channel 2: only the final stable high may qualify.
    bounce[0] = 4'h4; bounce[1] = 4'h0; bounce[2] = 4'h4;
    bounce[3] = 4'h4; bounce[4] = 4'h0; bounce[5] = 4'h4;
    do_reset(4'h0, 2);
    rise_cnt = 0; fall_cnt = 0; rise_edge = 0;
    for (int k = 1; k <= 16; k++) begin
      cycle((k <= 6) ? bounce[k-1] : 4'h4, 1'b1);
      if (bus0.rise[2]) begin rise_cnt++; rise_edge = k; end
      if (bus0.fall[2]) fall_cnt++;
    end
    chk("bounce_rises", CH'(rise_cnt), CH'(1));
    chk("bounce_edge", CH'(rise_edge), CH'(11));
    chk("bounce_falls", CH'(fall_cnt), CH'(0));

    // One tick in four: four qualifying ticks land on edge 16.
    do_reset(4'h0, 2);
    hit = 0;
    for (int k = 1; k <= 24; k++) begin
      cycle(4'h8, (k % 4) == 0);
      if (bus0.dout[3] && hit == 0) hit = k;
    end
    chk("tick_gate_edge", CH'(hit), CH'(16));

    // Reset in the middle of channel 0's count, with channel 1 already accepted.
    do_reset(4'h0, 2);
    for (int k = 1; k <= 7; k++) cycle(4'h2, 1'b1);
    chk("mid_pre_dout", bus0.dout, 4'h2);
    for (int k = 1; k <= 4; k++) cycle(4'h3, 1'b1);
    do_reset(4'h3, 2);
    hit = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle(4'h3, 1'b1);
      if (k < 6) chk("mid_early_dout", bus0.dout, 4'h0);
      if (k == 6) chk("mid_rise", bus0.rise, 4'h3);
    end

    // Randomized run with biased holds, random strobes and occasional resets.
    do_reset(4'h0, 2);
    d = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 5) == 0) d[c] = ~d[c];
      if ($urandom_range(0, 299) == 0) do_reset(d, $urandom_range(1, 3));
      cycle(d, ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
